// File: rtl/mult_div_seq.sv
// Sequential signed 32-bit divider: restoring algorithm on magnitudes, one
// quotient bit per clock, with zero-divisor and signed-overflow detection.
module mult_div_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] res_q, res_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic        exc_q, exc_d;

  logic [32:0] rem_sh, trial;
  logic [31:0] mag_a, mag_b;

  // Two's-complement negation of 0x80000000 yields 0x80000000, i.e. unsigned 2^31.
  assign mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  // The dividend sits in quo_q and shifts out of its MSB into the remainder.
  assign rem_sh = {rem_q, quo_q[31]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    sign_d  = sign_q;
    err_d   = err_q;
    exc_d   = exc_q;
    if (ctrl_DIV) begin
      state_d = BUSY;
      cnt_d   = 6'd0;
      rem_d   = 32'd0;
      quo_d   = mag_a;
      dvs_d   = mag_b;
      sign_d  = data_operandA[31] ^ data_operandB[31];
      err_d   = (data_operandB == 32'd0) ||
                (data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF);
    end else begin
      case (state_q)
        BUSY: begin
          if (err_q) begin
            state_d = DONE;
            res_d   = 32'd0;
            exc_d   = 1'b1;
          end else if (cnt_q == 6'd32) begin
            state_d = DONE;
            res_d   = sign_q ? (~quo_q + 32'd1) : quo_q;
            exc_d   = 1'b0;
          end else begin
            // Remainder stays below the divisor, so 32 bits hold the kept value.
            rem_d = trial[32] ? rem_sh[31:0] : trial[31:0];
            quo_d = {quo_q[30:0], ~trial[32]};
            cnt_d = cnt_q + 6'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      res_q   <= 32'd0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed and random checks of mult_div_seq against a latency/quotient model.
module tb_mult_div_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] op_a  = 32'd0;
  logic [31:0] op_b  = 32'd0;
  logic        ctrl  = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int compared   = 0;
  int mismatched = 0;

  mult_div_seq dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_DIV       (ctrl),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed truncating divide, with exception cases and fixed latencies.
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] q, output logic e, output int lat);
    int xi, yi;
    xi = x;
    yi = y;
    if (y == 32'd0 || (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) begin
      q = 32'd0; e = 1'b1; lat = 1;
    end else begin
      q = 32'(xi / yi); e = 1'b0; lat = 33;
    end
  endtask

  // Cycle model: pending division counts down edges; held outputs change only on completion.
  bit          live = 0, armed = 0;
  int          left = 0;
  logic [31:0] p_res = 0, m_res = 0;
  logic        p_exc = 0, m_exc = 0, m_rdy = 0;

  always @(posedge clock) begin
    #1;
    if (reset) begin
      armed = 0; m_rdy = 0; m_res = 0; m_exc = 0; live = 1;
    end else if (ctrl) begin
      ref_div(op_a, op_b, p_res, p_exc, left);
      armed = 1; m_rdy = 0;
    end else begin
      m_rdy = 0;
      if (armed) begin
        left--;
        if (left == 0) begin
          armed = 0; m_rdy = 1; m_res = p_res; m_exc = p_exc;
        end
      end
    end
    if (live) begin
      chk("model_rdy", 32'(data_resultRDY), 32'(m_rdy));
      chk("model_result", data_result, m_res);
      chk("model_exc", 32'(data_exception), 32'(m_exc));
    end
  end

  // Start a division, scramble operands afterwards, then time the RDY pulse.
  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ee, input int elat);
    int got;
    got = 0;
    @(negedge clock);
    op_a = a; op_b = b; ctrl = 1'b1;
    @(negedge clock);
    ctrl = 1'b0; op_a = $urandom; op_b = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #2;
      if (data_resultRDY) begin
        got = k;
        break;
      end
    end
    chk({name, "_lat"}, 32'(got), 32'(elat));
    chk({name, "_res"}, data_result, er);
    chk({name, "_exc"}, 32'(data_exception), 32'(ee));
  endtask

  initial begin
    logic [31:0] ra, rb, rq;
    logic        re;
    int          rl;

    repeat (2) @(posedge clock);
    #2;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", 32'(data_exception), 32'd0);
    chk("reset_rdy", 32'(data_resultRDY), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run("d100_7", 32'd100, 32'd7, 32'd14, 1'b0, 33);
    @(posedge clock);
    #2;
    chk("rdy_one_cycle", 32'(data_resultRDY), 32'd0);

    run("dm100_7",   32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, 33);
    run("dm100_m7",  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0, 33);
    run("d7_100",    32'd7,         32'd100,       32'd0,         1'b0, 33);
    run("div_zero",  32'd12345,     32'd0,         32'd0,         1'b1, 1);
    run("ovf",       32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 1);
    run("min_2",     32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0, 33);
    run("min_1",     32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 33);
    run("max_m1",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 33);
    run("m7_2",      32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33);
    run("z_5",       32'd0,         32'd5,         32'd0,         1'b0, 33);

    // Restart mid-division: only the second division completes.
    @(negedge clock);
    op_a = 32'd100; op_b = 32'd7; ctrl = 1'b1;
    @(negedge clock);
    ctrl = 1'b0;
    repeat (8) @(negedge clock);
    run("restart", 32'd50, 32'd5, 32'd10, 1'b0, 33);

    // Reset mid-division abandons it; outputs clear on the next edge.
    @(negedge clock);
    op_a = 32'd1000; op_b = 32'd3; ctrl = 1'b1;
    @(negedge clock);
    ctrl = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #2;
    chk("rst_mid_result", data_result, 32'd0);
    chk("rst_mid_exc", 32'(data_exception), 32'd0);
    chk("rst_mid_rdy", 32'(data_resultRDY), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run("after_rst", 32'd9, 32'd3, 32'd3, 1'b0, 33);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = 32'($urandom_range(1, 300));
      if (rb == 32'd0) rb = 32'd1;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      ref_div(ra, rb, rq, re, rl);
      run("rand", ra, rb, rq, re, rl);
    end

    repeat (3) @(posedge clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
